pipe_ctrl: RTL and testbench

Central sequencing controller for the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It generates per-latch enable and flush strobes, pc_en, and gated cache requests. Inputs are instruction and data cache hit status, the memory-stage request, load-use operands, and control-transfer events. It makes the stages advance together only when both memory ports are satisfied, and it records a hit that arrives early so the request is not re-issued. It also inserts load-use bubbles, squashes wrong-path instructions and freezes the machine on halt.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/pipe_ctrl_if.sv | 43 ++++
 rtl/pipe_ctrl_hazard_detect.sv | 44 ++++
 rtl/pipe_ctrl.sv | 91 +++++++++
 tb/tb_pipe_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, controller state and the per-latch control vector.
package cpu_types_pkg;

  localparam int CNT_W = 16;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic pcEn;
    logic ifidEn;
    logic idexEn;
    logic exmemEn;
    logic memwbEn;
    logic ifidFlush;
    logic idexFlush;
    logic exmemFlush;
  } latchCtrl_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline controller bundle: cache status, hazard operands in, latch strobes and gated requests out.
interface pipe_ctrl_if;
  import cpu_types_pkg::*;

  logic             ihit;
  logic             dhit;
  logic             exmem_dREN;
  logic             exmem_dWEN;
  logic             exmem_halt;
  logic             idex_dREN;
  regbits_t         idex_wsel;
  regbits_t         ifid_rs;
  regbits_t         ifid_rt;
  logic             branch_taken;
  logic             jump;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             dREN;
  logic             dWEN;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;

  modport pc (
    input  ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, idex_dREN,
           idex_wsel, ifid_rs, ifid_rt, branch_taken, jump,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, dREN, dWEN, halt, stall_cnt
  );

  modport tb (
    output ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, idex_dREN,
           idex_wsel, ifid_rs, ifid_rt, branch_taken, jump,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, dREN, dWEN, halt, stall_cnt
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational hazard resolution: turns an advance cycle into per-latch enables and flushes.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic       adv,
  input  logic       branchTaken,
  input  logic       jump,
  input  logic       idexDREN,
  input  logic       exmemHalt,
  input  regbits_t   idexWsel,
  input  regbits_t   ifidRs,
  input  regbits_t   ifidRt,
  output latchCtrl_t ctrl
);

  logic loadUse;

  assign loadUse = idexDREN && (idexWsel != '0) &&
                   ((idexWsel == ifidRs) || (idexWsel == ifidRt));

  always_comb begin
    ctrl = '0;
    if (adv) begin
      ctrl.pcEn    = 1'b1;
      ctrl.ifidEn  = 1'b1;
      ctrl.idexEn  = 1'b1;
      ctrl.exmemEn = 1'b1;
      ctrl.memwbEn = 1'b1;
      // A taken branch squashes the dependent instruction anyway, so it hides the load-use stall.
      if (branchTaken) begin
        ctrl.ifidFlush = 1'b1;
        ctrl.idexFlush = 1'b1;
      end else if (loadUse) begin
        ctrl.pcEn      = 1'b0;
        ctrl.ifidEn    = 1'b0;
        ctrl.idexFlush = 1'b1;
      end else if (jump) begin
        ctrl.ifidFlush = 1'b1;
      end
      ctrl.exmemFlush = exmemHalt;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: advances all latches together once both cache ports are satisfied,
// remembering early hits so a completed access is not reissued.
module pipe_ctrl
  import cpu_types_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  pipe_ctrl_if.pc pcif
);

  logic             ihitQ;
  logic             dhitQ;
  state_t           stateReg;
  state_t           stateNext;
  logic [CNT_W-1:0] stallCnt;
  logic             memReq;
  logic             running;
  logic             adv;
  latchCtrl_t       ctrl;

  assign memReq  = pcif.exmem_dREN | pcif.exmem_dWEN;
  assign running = (stateReg != HALT);
  assign adv     = nRST & running & (pcif.ihit | ihitQ) &
                   (~memReq | pcif.dhit | dhitQ);

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      RUN: begin
        if (adv && pcif.exmem_halt)
          stateNext = HALT;
        else if (!adv && (pcif.ihit || pcif.dhit))
          stateNext = PEND;
      end
      PEND: begin
        if (adv)
          stateNext = pcif.exmem_halt ? HALT : RUN;
      end
      HALT:    stateNext = HALT;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ihitQ    <= 1'b0;
      dhitQ    <= 1'b0;
      stateReg <= RUN;
      stallCnt <= '0;
    end else begin
      if (adv) begin
        ihitQ <= 1'b0;
        dhitQ <= 1'b0;
      end else begin
        if (pcif.ihit) ihitQ <= 1'b1;
        if (pcif.dhit) dhitQ <= 1'b1;
      end
      stateReg <= stateNext;
      if (running && !adv && (stallCnt != {CNT_W{1'b1}}))
        stallCnt <= stallCnt + 1'b1;
    end
  end

  hazard_detect u_hazard (
    .adv         (adv),
    .branchTaken (pcif.branch_taken),
    .jump        (pcif.jump),
    .idexDREN    (pcif.idex_dREN),
    .exmemHalt   (pcif.exmem_halt),
    .idexWsel    (pcif.idex_wsel),
    .ifidRs      (pcif.ifid_rs),
    .ifidRt      (pcif.ifid_rt),
    .ctrl        (ctrl)
  );

  assign pcif.pc_en       = ctrl.pcEn;
  assign pcif.ifid_en     = ctrl.ifidEn;
  assign pcif.idex_en     = ctrl.idexEn;
  assign pcif.exmem_en    = ctrl.exmemEn;
  assign pcif.memwb_en    = ctrl.memwbEn;
  assign pcif.ifid_flush  = ctrl.ifidFlush;
  assign pcif.idex_flush  = ctrl.idexFlush;
  assign pcif.exmem_flush = ctrl.exmemFlush;

  // A latched data hit means the access already completed; keep it from going out again.
  assign pcif.dREN      = nRST & running & pcif.exmem_dREN & ~dhitQ;
  assign pcif.dWEN      = nRST & running & pcif.exmem_dWEN & ~dhitQ;
  assign pcif.halt      = nRST & ~running;
  assign pcif.stall_cnt = nRST ? stallCnt : '0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table of single-cycle vectors plus multi-cycle sequences.
module tb_pipe_ctrl;
  import cpu_types_pkg::*;

  // Output order: pc,ifid,idex,exmem,memwb, ifidF,idexF,exmemF, dREN,dWEN,halt
  localparam logic [10:0] ALL  = 11'b11111_000_000;
  localparam logic [10:0] NONE = 11'b00000_000_000;
  localparam logic [10:0] RD   = 11'b00000_000_100;
  localparam logic [10:0] LU   = 11'b00111_010_000;
  localparam logic [10:0] HLT  = 11'b00000_000_001;

  typedef struct packed {
    logic        ihit, dhit, exR, exW, exH, idR;
    logic [4:0]  wsel, rs, rt;
    logic        br, jmp;
    logic [10:0] exp;
  } vec_t;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   errCnt = 0;
  int   chkCnt = 0;
  logic [10:0] expQ[$];
  vec_t tbl[12];

  pipe_ctrl_if bus();

  pipe_ctrl dut (
    .CLK  (CLK),
    .nRST (nRST),
    .pcif (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(logic ihit, logic dhit, logic exR, logic exW, logic exH,
                              logic idR, logic [4:0] wsel, logic [4:0] rs, logic [4:0] rt,
                              logic br, logic jmp, logic [10:0] exp);
    vec_t v;
    v.ihit = ihit; v.dhit = dhit; v.exR = exR; v.exW = exW; v.exH = exH; v.idR = idR;
    v.wsel = wsel; v.rs = rs; v.rt = rt; v.br = br; v.jmp = jmp; v.exp = exp;
    return v;
  endfunction

  task automatic setInputs(input vec_t v);
    bus.ihit = v.ihit; bus.dhit = v.dhit;
    bus.exmem_dREN = v.exR; bus.exmem_dWEN = v.exW; bus.exmem_halt = v.exH;
    bus.idex_dREN = v.idR; bus.idex_wsel = v.wsel;
    bus.ifid_rs = v.rs; bus.ifid_rt = v.rt;
    bus.branch_taken = v.br; bus.jump = v.jmp;
  endtask

  task automatic checkNow(input logic [10:0] e, input string tag);
    logic [10:0] got, want;
    expQ.push_back(e);
    got = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
           bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.dREN, bus.dWEN, bus.halt};
    want = expQ.pop_front();
    chkCnt++;
    if (got !== want) begin
      errCnt++;
      $display("FAIL %s: got=%b expected=%b", tag, got, want);
    end else begin
      $display("ok   %s: outputs=%b", tag, got);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, sample mid-low-phase.
  task automatic apply(input vec_t v, input string tag);
    @(negedge CLK);
    setInputs(v);
    #2;
    checkNow(v.exp, tag);
  endtask

  // Sample the counter just after the edge that follows the last applied cycle.
  task automatic checkCnt(input logic [CNT_W-1:0] e, input string tag);
    @(posedge CLK);
    #1;
    chkCnt++;
    if (bus.stall_cnt !== e) begin
      errCnt++;
      $display("FAIL %s: stall_cnt got=%0d expected=%0d", tag, bus.stall_cnt, e);
    end else begin
      $display("ok   %s: stall_cnt=%0d", tag, bus.stall_cnt);
    end
  endtask

  task automatic doReset(input string tag);
    @(negedge CLK);
    nRST = 1'b0;
    setInputs(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
    #2;
    checkNow(NONE, tag);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    setInputs(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));

    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, ALL);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NONE);
    tbl[2]  = mk(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 11'b11111_000_100);
    tbl[3]  = mk(1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 11'b11111_000_010);
    tbl[4]  = mk(1, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd2, 0, 0, LU);
    tbl[5]  = mk(1, 0, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, LU);
    tbl[6]  = mk(1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, ALL);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5, 0, 0, ALL);
    tbl[8]  = mk(1, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 11'b11111_110_000);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 5'd3, 5'd4, 5'd6, 0, 1, 11'b11111_100_000);
    tbl[10] = mk(1, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 0, 1, LU);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, NONE);

    // Reset, then steady-state advance with no memory op
    doReset("reset_outputs_zero");
    for (int i = 0; i < 4; i++) apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL), $sformatf("run_%0d", i));
    checkCnt(0, "run_no_stalls");

    // Table vectors
    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec_%0d", i));

    // dhit first, ihit three cycles later
    doReset("reset_split");
    apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, RD),   "split_c1_wait");
    apply(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, RD),   "split_c2_dhit");
    apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, NONE), "split_c3_dren_dropped");
    apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, NONE), "split_c4_pend");
    apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, ALL),  "split_c5_adv");
    checkCnt(4, "split_stall_cnt");
    // ihit first: latched ihit pairs with a later dhit
    apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, RD),   "ifirst_c1_latch");
    apply(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 11'b11111_000_100), "ifirst_c2_adv");
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL),  "ifirst_c3_run");
    // both hits arriving together with a latched hit
    apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, RD),   "both_c1_latch");
    apply(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 11'b11111_000_100), "both_c2_adv");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE), "both_c3_latch_cleared");
    checkCnt(7, "split_total_stalls");

    // Halt: flush EX/MEM, then frozen until reset
    doReset("reset_halt");
    apply(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 11'b11111_001_000), "halt_adv_flush");
    for (int i = 0; i < 20; i++)
      apply(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, HLT), $sformatf("halt_hold_%0d", i));
    checkCnt(0, "halt_no_count");

    // Async reset while pending with a latched data hit
    doReset("reset_pend");
    apply(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, RD),   "pend_c1_dhit");
    apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, NONE), "pend_c2_suppressed");
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    checkNow(NONE, "pend_in_reset");
    #1;
    nRST = 1'b1;
    #1;
    checkNow(RD, "pend_after_release_dren");
    apply(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 11'b11111_000_100), "pend_after_release_adv");

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
